// File: rtl/dma_reader_pkg.sv
// Shared DMA definitions: bus geometry, memory latency, block base address
// and the DMA state encoding used by the read and write engines.
package dma_reader_pkg;
  localparam int WORD_SIZE      = 16;
  localparam int BLOCK_WORDS    = 4;
  localparam int NUM_BLOCKS     = 3;
  localparam int MEMORY_LATENCY = 4;
  localparam logic [WORD_SIZE-1:0] BASE_ADDR = 16'h01f4;

  localparam int BLK_W = BLOCK_WORDS * WORD_SIZE;
  localparam int LAT_W = (MEMORY_LATENCY > 1) ? $clog2(MEMORY_LATENCY) : 1;
  localparam int OFF_W = 2;

  typedef enum logic [2:0] {IDLE, REQ, RD, DLV, DONE} dma_state_t;

  // Block address; the add wraps at WORD_SIZE bits with no carry out.
  function automatic logic [WORD_SIZE-1:0] blk_addr(input logic [OFF_W-1:0] off);
    return BASE_ADDR + WORD_SIZE'(off) * WORD_SIZE'(BLOCK_WORDS);
  endfunction
endpackage

// File: rtl/dma_reader_if.sv
// Bus-arbitration and device handshake signals of the read DMA.
interface dma_reader_if;
  import dma_reader_pkg::*;
  logic             BR;
  logic             BG;
  logic [BLK_W-1:0] mem_data;
  logic [BLK_W-1:0] dev_data;
  logic             dev_valid;
  logic             dev_ready;

  modport master (output BR, dev_data, dev_valid,
                  input  BG, mem_data, dev_ready);
  modport slave  (input  BR, dev_data, dev_valid,
                  output BG, mem_data, dev_ready);
endinterface

// File: rtl/dma_lat_counter.sv
// Memory latency counter: counts while enabled, clear wins over enable,
// tc flags the last cycle of the access window.
module dma_lat_counter
  import dma_reader_pkg::*;
#(
  parameter int N = MEMORY_LATENCY,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == W'(N - 1));
endmodule

// File: rtl/dma_reader.sv
// Memory-to-device DMA: requests the bus, reads NUM_BLOCKS blocks upward
// from BASE_ADDR and hands each one to the device over valid/ready.
module dma_reader
  import dma_reader_pkg::*;
(
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 cmd,
  dma_reader_if.master         bus,
  output logic                 READ,
  output logic [WORD_SIZE-1:0] addr,
  output logic [OFF_W-1:0]     offset,
  output logic                 interrupt
);
  dma_state_t       state_q;
  logic             br_q, dev_valid_q, irq_q;
  logic [OFF_W-1:0] offset_q;
  logic [BLK_W-1:0] dev_data_q;
  logic             drive, lat_tc, last_blk;

  // The memory bus is ours only while reading with grant present.
  assign drive    = (state_q == RD) && bus.BG;
  assign last_blk = (offset_q == OFF_W'(NUM_BLOCKS - 1));
  assign READ     = drive ? 1'b1 : 1'bz;
  assign addr     = drive ? blk_addr(offset_q) : {WORD_SIZE{1'bz}};

  // Latency window restarts on every block and on any grant loss.
  dma_lat_counter #(.N(MEMORY_LATENCY)) u_lat (
    .clk (CLK),
    .rst (reset),
    .en  (drive),
    .clr (!drive || lat_tc),
    .tc  (lat_tc)
  );

  // Transfer FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      br_q        <= 1'b0;
      dev_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      offset_q    <= '0;
      dev_data_q  <= '0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd) begin
          state_q  <= REQ;
          br_q     <= 1'b1;
          offset_q <= '0;
        end
        REQ: if (bus.BG) state_q <= RD;
        RD: begin
          if (!bus.BG) begin
            state_q <= REQ;
          end else if (lat_tc) begin
            dev_data_q  <= bus.mem_data;
            dev_valid_q <= 1'b1;
            state_q     <= DLV;
            if (last_blk) br_q <= 1'b0;
          end
        end
        DLV: if (bus.dev_ready) begin
          dev_valid_q <= 1'b0;
          if (last_blk) begin
            state_q <= DONE;
            irq_q   <= 1'b1;
          end else begin
            offset_q <= offset_q + OFF_W'(1);
            state_q  <= bus.BG ? RD : REQ;
          end
        end
        DONE: begin
          offset_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BR        = br_q;
  assign bus.dev_valid = dev_valid_q;
  assign bus.dev_data  = dev_data_q;
  assign offset        = offset_q;
  assign interrupt     = irq_q;
endmodule

// File: tb/tb_dma_reader.sv
// Directed bench for dma_reader: nominal transfer, backpressure, grant loss,
// reset mid-transfer, back-to-back commands and cmd while busy.
module tb_dma_reader;
  import dma_reader_pkg::*;

  logic                 CLK = 1'b0;
  logic                 reset, cmd;
  wire                  READ;
  wire  [WORD_SIZE-1:0] addr;
  logic [OFF_W-1:0]     offset;
  logic                 interrupt;
  int                   checks = 0;
  int                   failures = 0;

  dma_reader_if bus ();

  dma_reader dut (
    .CLK       (CLK),
    .reset     (reset),
    .cmd       (cmd),
    .bus       (bus),
    .READ      (READ),
    .addr      (addr),
    .offset    (offset),
    .interrupt (interrupt)
  );

  always #5 CLK = ~CLK;

  // Memory: word i of the block at address a holds the value a+i.
  assign bus.mem_data = (READ === 1'b1) ?
    {addr + 16'd3, addr + 16'd2, addr + 16'd1, addr} : 64'h0;

  localparam logic [63:0] BLK0 = 64'h01f7_01f6_01f5_01f4;
  localparam logic [63:0] BLK1 = 64'h01fb_01fa_01f9_01f8;
  localparam logic [63:0] BLK2 = 64'h01ff_01fe_01fd_01fc;
  localparam logic [15:0] ADR0 = 16'h01f4;
  localparam logic [15:0] ADR1 = 16'h01f8;
  localparam logic [15:0] ADR2 = 16'h01fc;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for READ, then count its high cycles while checking the address.
  task automatic do_read(input logic [15:0] a, input int exp_n);
    int w = 0;
    int n = 0;
    while (READ !== 1'b1 && w < 30) begin tick(); w++; end
    chk("rd_start", 64'(w < 30), 64'd1);
    while (READ === 1'b1 && n < 20) begin
      chk("rd_addr", 64'(addr), 64'(a));
      n++;
      tick();
    end
    chk("rd_len", 64'(n), 64'(exp_n));
  endtask

  // One full block with device ready; leaves the bench just past the handshake.
  task automatic blk(input int k, input logic [15:0] a, input logic [63:0] d);
    do_read(a, 4);
    chk("dv_valid", 64'(bus.dev_valid), 64'd1);
    chk("dv_data", bus.dev_data, d);
    chk("dv_offset", 64'(offset), 64'(k));
    chk("br_hold", 64'(bus.BR), (k == 2) ? 64'd0 : 64'd1);
    tick();
  endtask

  // Called in the DONE cycle; ends in the following IDLE cycle.
  task automatic done_chk;
    chk("irq_hi", 64'(interrupt), 64'd1);
    chk("irq_dv", 64'(bus.dev_valid), 64'd0);
    tick();
    chk("irq_lo", 64'(interrupt), 64'd0);
    chk("irq_off", 64'(offset), 64'd0);
    chk("irq_br", 64'(bus.BR), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cmd = 1'b0; bus.BG = 1'b0; bus.dev_ready = 1'b1;
    tick(); tick();
    chk("rst_br", 64'(bus.BR), 64'd0);
    chk("rst_dv", 64'(bus.dev_valid), 64'd0);
    chk("rst_irq", 64'(interrupt), 64'd0);
    chk("rst_off", 64'(offset), 64'd0);
    chk("rst_data", bus.dev_data, 64'd0);
    chk("rst_read", 64'(READ === 1'b1), 64'd0);
    reset = 1'b0;
    tick();

    // 1. Nominal transfer, grant two cycles after BR.
    cmd = 1'b1; tick(); cmd = 1'b0;
    chk("s1_br", 64'(bus.BR), 64'd1);
    tick(); tick();
    chk("s1_noread", 64'(READ === 1'b1), 64'd0);
    bus.BG = 1'b1; #1;
    blk(0, ADR0, BLK0);
    blk(1, ADR1, BLK1);
    blk(2, ADR2, BLK2);
    done_chk();

    // 2. Device backpressure on block 1.
    cmd = 1'b1; tick(); cmd = 1'b0;
    blk(0, ADR0, BLK0);
    bus.dev_ready = 1'b0;
    do_read(ADR1, 4);
    for (int i = 0; i < 5; i++) begin
      chk("s2_valid", 64'(bus.dev_valid), 64'd1);
      chk("s2_data", bus.dev_data, BLK1);
      chk("s2_noread", 64'(READ === 1'b1), 64'd0);
      tick();
    end
    bus.dev_ready = 1'b1;
    blk(2, ADR2, BLK2);
    done_chk();

    // 3. Grant loss at lat_cnt=2 on block 0.
    bus.BG = 1'b0;
    cmd = 1'b1; tick(); cmd = 1'b0;
    bus.BG = 1'b1; tick();
    chk("s3_rd0", 64'(READ === 1'b1), 64'd1);
    tick(); tick();
    chk("s3_rd2", 64'(READ === 1'b1), 64'd1);
    bus.BG = 1'b0; #1;
    chk("s3_z_read", 64'(READ === 1'b1), 64'd0);
    chk("s3_br", 64'(bus.BR), 64'd1);
    tick(); tick();
    chk("s3_z_read2", 64'(READ === 1'b1), 64'd0);
    chk("s3_br2", 64'(bus.BR), 64'd1);
    chk("s3_dv", 64'(bus.dev_valid), 64'd0);
    bus.BG = 1'b1; #1;
    blk(0, ADR0, BLK0);
    blk(1, ADR1, BLK1);
    blk(2, ADR2, BLK2);
    done_chk();

    // 4. Reset during DLV of block 1.
    cmd = 1'b1; tick(); cmd = 1'b0;
    blk(0, ADR0, BLK0);
    bus.dev_ready = 1'b0;
    do_read(ADR1, 4);
    chk("s4_in_dlv", 64'(bus.dev_valid), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    bus.dev_ready = 1'b1;
    chk("s4_br", 64'(bus.BR), 64'd0);
    chk("s4_dv", 64'(bus.dev_valid), 64'd0);
    chk("s4_off", 64'(offset), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("s4_noirq", 64'(interrupt), 64'd0);
      chk("s4_idle_br", 64'(bus.BR), 64'd0);
      tick();
    end
    cmd = 1'b1; tick(); cmd = 1'b0;
    blk(0, ADR0, BLK0);
    blk(1, ADR1, BLK1);
    blk(2, ADR2, BLK2);
    done_chk();

    // 6. Back-to-back: cmd in the cycle right after the interrupt.
    cmd = 1'b1; tick(); cmd = 1'b0;
    chk("s6_br", 64'(bus.BR), 64'd1);
    chk("s6_off", 64'(offset), 64'd0);
    blk(0, ADR0, BLK0);
    blk(1, ADR1, BLK1);
    blk(2, ADR2, BLK2);
    done_chk();

    // 5. cmd pulses during RD and DLV are ignored.
    cmd = 1'b1; tick(); cmd = 1'b0;
    tick();
    chk("s5_rd", 64'(READ === 1'b1), 64'd1);
    cmd = 1'b1; tick(); cmd = 1'b0;
    do_read(ADR0, 3);
    chk("s5_data0", bus.dev_data, BLK0);
    cmd = 1'b1; tick(); cmd = 1'b0;
    blk(1, ADR1, BLK1);
    blk(2, ADR2, BLK2);
    done_chk();
    for (int i = 0; i < 4; i++) begin
      chk("s5_noirq", 64'(interrupt), 64'd0);
      chk("s5_idle_br", 64'(bus.BR), 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
